pwm_pack_4: RTL



---
 rtl/pwm_pack_4_if.sv | 22 ++
 rtl/pwm_pack_4.sv | 124 ++++++++++++
 2 files changed

// File: rtl/pwm_pack_4_if.sv
// Handshake channels of pwm_pack_4: coefficient-pair input and packed-frame output.
interface pwm_pack_4_if #(
  parameter int N = 9
) ();
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   in_a;
  logic [N-1:0]   in_b;
  logic           out_valid;
  logic           out_ready;
  logic [4*N-1:0] out_an;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_an
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_an
  );
endinterface

// File: rtl/pwm_pack_4.sv
// Pointwise a*b mod Q multiplier packing 4 products per frame for the INTT core.
// Optional sticky range-check flag err is built when PWM_RANGE_CHK_EN is defined.
module pwm_pack_4 #(
  parameter int N      = 9,
  parameter int Q      = 257,
  parameter int POINTS = 4
) (
  input  logic clk,
  input  logic rst_n,
`ifdef PWM_RANGE_CHK_EN
  output logic err,
`endif
  pwm_pack_4_if.slave bus
);

  localparam int                LANE_W = $clog2(POINTS);
  localparam logic [LANE_W-1:0] LAST   = LANE_W'(POINTS - 1);
  localparam int                PW     = (2 * N > 18) ? 2 * N : 18;

  function automatic logic [N-1:0] reduce_q(input logic [2*N-1:0] p);
    logic [PW-1:0]      pw;
    logic signed [11:0] t;
    pw = PW'(p);
    if (Q == 257 && N == 9) begin
      // 2^8 = -1 (mod 257): p = h1*2^16 + h0*2^8 + l  ->  l - h0 + h1, range [-255, 258]
      t = $signed(12'(pw[7:0])) - $signed(12'(pw[15:8])) + $signed(12'(pw[17:16]));
      if (t < 12'sd0)
        t = t + 12'sd257;
      else if (t >= 12'sd257)
        t = t - 12'sd257;
      reduce_q = N'(t);
    end else begin
      reduce_q = N'(32'(p) % 32'(Q));
    end
  endfunction

  logic [2*N-1:0]      r_prod_p0;
  logic                r_vld_p0;
  logic [N-1:0]        r_buf_p1 [POINTS-1];
  logic [LANE_W-1:0]   r_lane_cnt;
  logic [POINTS*N-1:0] r_out_an;
  logic                r_out_valid;
  logic                r_rdy_en;

  logic                w_stall;
  logic                w_advance;
  logic                w_in_ready;
  logic                w_accept;
  logic [N-1:0]        w_r;
  logic [POINTS*N-1:0] w_frame;

  // Only the last lane needs the output slot; earlier lanes always drain.
  assign w_stall    = r_vld_p0 && (r_lane_cnt == LAST) && r_out_valid && !bus.out_ready;
  assign w_advance  = r_vld_p0 && !w_stall;
  assign w_in_ready = r_rdy_en && (!r_vld_p0 || !w_stall);
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_r        = reduce_q(r_prod_p0);

  always_comb begin
    w_frame = '0;
    for (int i = 0; i < POINTS - 1; i++)
      w_frame[N*i +: N] = r_buf_p1[i];
    w_frame[N*(POINTS-1) +: N] = w_r;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_rdy_en <= 1'b0;
    else
      r_rdy_en <= 1'b1;
  end

  // ---- stage P: exact product register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prod_p0 <= '0;
      r_vld_p0  <= 1'b0;
    end else if (w_accept) begin
      r_prod_p0 <= (2*N)'(bus.in_a) * (2*N)'(bus.in_b);
      r_vld_p0  <= 1'b1;
    end else if (w_advance) begin
      r_vld_p0  <= 1'b0;
    end
  end

  // ---- stage R: reduce, write lane, launch frame on the last lane
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < POINTS - 1; i++)
        r_buf_p1[i] <= '0;
      r_lane_cnt  <= '0;
      r_out_an    <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_advance && r_lane_cnt != LAST) begin
        r_buf_p1[r_lane_cnt] <= w_r;
        r_lane_cnt           <= r_lane_cnt + 1'b1;
      end
      if (w_advance && r_lane_cnt == LAST) begin
        r_out_an    <= w_frame;
        r_out_valid <= 1'b1;
        r_lane_cnt  <= '0;
      end else if (r_out_valid && bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

`ifdef PWM_RANGE_CHK_EN
  localparam logic [N-1:0] Q_N = N'(Q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err <= 1'b0;
    else if (w_accept && (bus.in_a >= Q_N || bus.in_b >= Q_N))
      err <= 1'b1;
  end
`endif

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_an    = r_out_an;

endmodule
